// File: rtl/axis_frame_checker_pkg.sv
// Shared types and helpers for the AXI4-Stream frame checker.
package axis_chk_pkg;

   localparam int C_CNT_WIDTH_DEF = 16;

   typedef enum logic [1:0] {
      IDLE,
      IN_FRAME,
      RESYNC
   } chkState_t;

   // Width-agnostic saturating increment; callers size the operands to their counter.
   function automatic logic [63:0] satInc(input logic [63:0] value, input logic [63:0] maxValue);
      return (value == maxValue) ? value : value + 64'd1;
   endfunction

endpackage

// File: rtl/axis_frame_checker_ready_throttle.sv
// Free-running modulo counter that pulls tready low one cycle in every C_STALL_PERIOD.
module axis_ready_throttle #(
   parameter int C_STALL_PERIOD = 0
) (
   input  logic Clk,
   input  logic Reset,
   output logic Stall
);

   localparam bit STALL_EN = (C_STALL_PERIOD >= 2);
   localparam int CNT_W    = (C_STALL_PERIOD > 2) ? $clog2(C_STALL_PERIOD) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_EN ? C_STALL_PERIOD - 1 : 0);

   logic [CNT_W-1:0] stallCnt;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         stallCnt <= '0;
      end else if (!STALL_EN || stallCnt == CNT_LAST) begin
         stallCnt <= '0;
      end else begin
         stallCnt <= stallCnt + 1'b1;
      end
   end

   assign Stall = STALL_EN && (stallCnt == '0);

endmodule

// File: rtl/axis_frame_checker.sv
// AXI4-Stream sink that checks incrementing-pattern frames and keeps saturating error statistics.
module axis_frame_checker
   import axis_chk_pkg::*;
#(
   parameter int C_S_AXIS_TDATA_WIDTH = 8,
   parameter int C_CNT_WIDTH          = C_CNT_WIDTH_DEF,
   parameter int C_STALL_PERIOD       = 0
) (
   input  logic                            Clk,
   input  logic                            Reset,
   input  logic                            En,
   input  logic [7:0]                      FrameSize,
   input  logic                            ClearCounters,
   input  logic [C_S_AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
   input  logic                            S_AXIS_tvalid,
   input  logic                            S_AXIS_tlast,
   output logic                            S_AXIS_tready,
   output logic [C_CNT_WIDTH-1:0]          FrameCount,
   output logic [C_CNT_WIDTH-1:0]          DataErrCount,
   output logic [C_CNT_WIDTH-1:0]          LenErrCount,
   output logic                            ErrorFlag,
   output logic                            FrameDone,
   output logic                            FrameOk
);

   localparam logic [C_CNT_WIDTH-1:0] CNT_MAX = '1;

   function automatic logic [C_CNT_WIDTH-1:0] bump(input logic [C_CNT_WIDTH-1:0] value);
      return C_CNT_WIDTH'(satInc(64'(value), 64'(CNT_MAX)));
   endfunction

   chkState_t state, stateNext;
   logic [7:0] beatCnt, beatCntNext;
   logic [7:0] frameSizeR, frameSizeRNext;
   logic [7:0] curSize;
   logic       frameBad, frameBadNext;
   logic       stall, accept, checking, lastExp;
   logic       dataErr, earlyLast, missLast, lenErr, frameEnd;
   logic       frameDone_p1, frameOk_p1;
   logic [C_S_AXIS_TDATA_WIDTH-1:0] expData;

   axis_ready_throttle #(
      .C_STALL_PERIOD(C_STALL_PERIOD)
   ) uThrottle (
      .Clk  (Clk),
      .Reset(Reset),
      .Stall(stall)
   );

   assign S_AXIS_tready = En & ~stall & ~Reset;
   assign accept        = S_AXIS_tvalid & S_AXIS_tready;
   assign expData       = C_S_AXIS_TDATA_WIDTH'(beatCnt);

   always_comb begin
      stateNext      = state;
      beatCntNext    = beatCnt;
      frameSizeRNext = frameSizeR;
      frameBadNext   = frameBad;

      // A frame's first beat is judged against the live FrameSize; later beats use the latched copy.
      curSize   = (state == IDLE) ? FrameSize : frameSizeR;
      checking  = accept & (state != RESYNC);
      lastExp   = (beatCnt == curSize - 8'd1);
      dataErr   = checking & (S_AXIS_tdata != expData);
      earlyLast = checking & S_AXIS_tlast & ~lastExp;
      missLast  = checking & ~S_AXIS_tlast & lastExp;
      lenErr    = earlyLast | missLast;
      frameEnd  = accept & S_AXIS_tlast;

      if (accept && state == IDLE) begin
         frameSizeRNext = FrameSize;
      end
      if (dataErr || lenErr) begin
         frameBadNext = 1'b1;
      end

      if (frameEnd) begin
         stateNext    = IDLE;
         beatCntNext  = '0;
         frameBadNext = 1'b0;
      end else if (missLast) begin
         stateNext = RESYNC;
      end else if (checking) begin
         stateNext   = IN_FRAME;
         beatCntNext = beatCnt + 8'd1;
      end
   end

   // Stage p1: frame state plus the end-of-frame verdict registered off the accept edge.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state        <= IDLE;
         beatCnt      <= '0;
         frameSizeR   <= '0;
         frameBad     <= 1'b0;
         frameDone_p1 <= 1'b0;
         frameOk_p1   <= 1'b0;
      end else begin
         state        <= stateNext;
         beatCnt      <= beatCntNext;
         frameSizeR   <= frameSizeRNext;
         frameBad     <= frameBadNext;
         frameDone_p1 <= frameEnd;
         frameOk_p1   <= frameEnd & ~(frameBad | dataErr | lenErr);
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         FrameCount   <= '0;
         DataErrCount <= '0;
         LenErrCount  <= '0;
         ErrorFlag    <= 1'b0;
      end else if (ClearCounters) begin
         FrameCount   <= '0;
         DataErrCount <= '0;
         LenErrCount  <= '0;
         ErrorFlag    <= 1'b0;
      end else begin
         if (frameEnd) FrameCount   <= bump(FrameCount);
         if (dataErr)  DataErrCount <= bump(DataErrCount);
         if (lenErr)   LenErrCount  <= bump(LenErrCount);
         if (dataErr || lenErr) ErrorFlag <= 1'b1;
      end
   end

   assign FrameDone = frameDone_p1;
   assign FrameOk   = frameOk_p1;

endmodule

// File: tb/tb_axis_frame_checker.sv
// Bench for axis_frame_checker: an unstalled and a 1-in-4 stalled instance against a frame-level model.
module tb_axis_frame_checker;

   localparam int DW = 8;
   localparam int CW = 16;
   localparam int CNT_SAT = (1 << CW) - 1;

   logic Clk = 1'b0;
   logic Reset = 1'b1;
   logic En = 1'b0;
   logic ClearCounters = 1'b0;
   logic [7:0] FrameSize = 8'd7;

   logic [1:0][DW-1:0] tdata;
   logic [1:0]         tvalid, tlast, tready;
   logic [1:0][CW-1:0] frameCount, dataErrCount, lenErrCount;
   logic [1:0]         errorFlag, frameDone, frameOk;

   int nCmp = 0;
   int nBad = 0;
   bit doneLog[$];

   // model state, per instance
   int period [2] = '{0, 4};
   int mK [2], mSize [2], mCyc [2], mFc [2], mDe [2], mLe [2];
   bit mBad [2], mEf [2], mDone [2], mOk [2];

   always #5 Clk = ~Clk;

   axis_frame_checker #(.C_S_AXIS_TDATA_WIDTH(DW), .C_CNT_WIDTH(CW), .C_STALL_PERIOD(0)) dut0 (
      .Clk(Clk), .Reset(Reset), .En(En), .FrameSize(FrameSize), .ClearCounters(ClearCounters),
      .S_AXIS_tdata(tdata[0]), .S_AXIS_tvalid(tvalid[0]), .S_AXIS_tlast(tlast[0]),
      .S_AXIS_tready(tready[0]), .FrameCount(frameCount[0]), .DataErrCount(dataErrCount[0]),
      .LenErrCount(lenErrCount[0]), .ErrorFlag(errorFlag[0]), .FrameDone(frameDone[0]),
      .FrameOk(frameOk[0]));

   axis_frame_checker #(.C_S_AXIS_TDATA_WIDTH(DW), .C_CNT_WIDTH(CW), .C_STALL_PERIOD(4)) dut1 (
      .Clk(Clk), .Reset(Reset), .En(En), .FrameSize(FrameSize), .ClearCounters(ClearCounters),
      .S_AXIS_tdata(tdata[1]), .S_AXIS_tvalid(tvalid[1]), .S_AXIS_tlast(tlast[1]),
      .S_AXIS_tready(tready[1]), .FrameCount(frameCount[1]), .DataErrCount(dataErrCount[1]),
      .LenErrCount(lenErrCount[1]), .ErrorFlag(errorFlag[1]), .FrameDone(frameDone[1]),
      .FrameOk(frameOk[1]));

   task automatic chk(input string name, input int d, input longint act, input longint exp);
      nCmp++;
      if (act != exp) begin
         nBad++;
         $display("FAIL %s (dut%0d): got %0d, expected %0d at %0t", name, d, act, exp, $time);
      end
   endtask

   function automatic bit readyExp(input int d);
      return En && !Reset && !(period[d] >= 2 && (mCyc[d] % period[d]) == 0);
   endfunction

   // Frame-level rules: beat k of a frame is checked only while k < size; beat size-1 must carry tlast.
   task automatic modelStep(input int d);
      bit acc, de, le, fin;
      if (Reset) begin
         mK[d] = 0; mSize[d] = 0; mCyc[d] = 0; mFc[d] = 0; mDe[d] = 0; mLe[d] = 0;
         mBad[d] = 0; mEf[d] = 0; mDone[d] = 0; mOk[d] = 0;
      end else begin
         acc = tvalid[d] && readyExp(d);
         de = 0; le = 0; fin = 0;
         mDone[d] = 0;
         mOk[d] = 0;
         if (acc) begin
            if (mK[d] == 0) mSize[d] = (FrameSize == 8'd0) ? 256 : int'(FrameSize);
            if (mK[d] < mSize[d]) begin
               de = (int'(tdata[d]) != (mK[d] % (1 << DW)));
               le = ((mK[d] == mSize[d] - 1) != tlast[d]);
            end
            if (de || le) mBad[d] = 1;
            if (tlast[d]) begin
               fin = 1;
               mDone[d] = 1;
               mOk[d] = !mBad[d];
               mBad[d] = 0;
               mK[d] = 0;
            end else begin
               mK[d]++;
            end
         end
         if (ClearCounters) begin
            mFc[d] = 0; mDe[d] = 0; mLe[d] = 0; mEf[d] = 0;
         end else begin
            if (fin && mFc[d] < CNT_SAT) mFc[d]++;
            if (de && mDe[d] < CNT_SAT) mDe[d]++;
            if (le && mLe[d] < CNT_SAT) mLe[d]++;
            if (de || le) mEf[d] = 1;
         end
         mCyc[d]++;
      end
   endtask

   always @(posedge Clk) begin
      modelStep(0);
      modelStep(1);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("tready", d, tready[d], readyExp(d));
         chk("FrameCount", d, frameCount[d], mFc[d]);
         chk("DataErrCount", d, dataErrCount[d], mDe[d]);
         chk("LenErrCount", d, lenErrCount[d], mLe[d]);
         chk("ErrorFlag", d, errorFlag[d], mEf[d]);
         chk("FrameDone", d, frameDone[d], mDone[d]);
         if (mDone[d]) chk("FrameOk", d, frameOk[d], mOk[d]);
      end
      if (frameDone[0]) doneLog.push_back(frameOk[0]);
   end

   task automatic sendBeat(input int d, input logic [DW-1:0] data, input bit last, input bit clr);
      bit got, acc;
      got = 0;
      @(negedge Clk);
      tdata[d] = data;
      tlast[d] = last;
      tvalid[d] = 1'b1;
      ClearCounters = clr;
      for (int i = 0; i < 20 && !got; i++) begin
         acc = tready[d];
         @(posedge Clk);
         if (acc) got = 1;
         else @(negedge Clk);
      end
      chk("accept within bound", d, got, 1);
   endtask

   task automatic sendFrame(input int d, input int n, input int lastAt, input int errAt,
                            input logic [DW-1:0] errVal);
      for (int k = 0; k < n; k++) begin
         sendBeat(d, (k == errAt) ? errVal : DW'(k), (k == lastAt), 1'b0);
      end
   endtask

   task automatic idle(input int n);
      @(negedge Clk);
      tvalid = '0;
      tlast = '0;
      ClearCounters = 1'b0;
      repeat (n - 1) @(negedge Clk);
   endtask

   task automatic clearAll();
      @(negedge Clk);
      ClearCounters = 1'b1;
      @(negedge Clk);
      ClearCounters = 1'b0;
      doneLog.delete();
   endtask

   // Pins both the DUT and the model to hand-computed totals.
   task automatic pin(input string tag, input int d, input int fc, input int de, input int le, input int ef);
      chk({tag, " FrameCount"}, d, frameCount[d], fc);
      chk({tag, " DataErrCount"}, d, dataErrCount[d], de);
      chk({tag, " LenErrCount"}, d, lenErrCount[d], le);
      chk({tag, " ErrorFlag"}, d, errorFlag[d], ef);
      chk({tag, " model frames"}, d, mFc[d], fc);
      chk({tag, " model data errors"}, d, mDe[d], de);
      chk({tag, " model length errors"}, d, mLe[d], le);
   endtask

   task automatic checkLog(input string tag, input int n, input logic [7:0] okBits);
      chk({tag, " FrameDone pulses"}, 0, doneLog.size(), n);
      for (int i = 0; i < n; i++) begin
         if (i < doneLog.size()) chk({tag, " FrameOk sequence"}, i, doneLog[i], okBits[i]);
      end
   endtask

   initial begin
      int lows;
      tdata = '0;
      tvalid = '0;
      tlast = '0;
      repeat (3) @(negedge Clk);
      chk("reset tready", 0, tready[0], 0);
      chk("reset FrameCount", 0, frameCount[0], 0);
      chk("reset FrameDone", 0, frameDone[0], 0);
      chk("reset FrameOk", 0, frameOk[0], 0);
      chk("reset ErrorFlag", 0, errorFlag[0], 0);
      Reset = 1'b0;
      En = 1'b1;

      // three clean back-to-back frames
      repeat (3) sendFrame(0, 7, 6, -1, '0);
      idle(3);
      pin("clean", 0, 3, 0, 0, 0);
      checkLog("clean", 3, 8'b0000_0111);
      clearAll();

      // corrupt beat 3 of the middle frame
      sendFrame(0, 7, 6, -1, '0);
      sendFrame(0, 7, 6, 3, 8'h09);
      sendFrame(0, 7, 6, -1, '0);
      idle(3);
      pin("data error", 0, 3, 1, 0, 1);
      checkLog("data error", 3, 8'b0000_0101);
      clearAll();

      // early tlast, then a clean frame with an En pause and a mid-frame FrameSize change
      sendFrame(0, 5, 4, -1, '0);
      sendBeat(0, 8'd0, 1'b0, 1'b0);
      sendBeat(0, 8'd1, 1'b0, 1'b0);
      @(negedge Clk);
      FrameSize = 8'd3;
      En = 1'b0;
      tvalid[0] = 1'b0;
      repeat (2) @(negedge Clk);
      En = 1'b1;
      for (int k = 2; k < 7; k++) sendBeat(0, DW'(k), (k == 6), 1'b0);
      idle(3);
      FrameSize = 8'd7;
      pin("early tlast", 0, 2, 0, 1, 1);
      checkLog("early tlast", 2, 8'b0000_0010);
      clearAll();

      // missing tlast: data runs 0..8, tlast on 8, then a clean frame
      sendFrame(0, 9, 8, -1, '0);
      sendFrame(0, 7, 6, -1, '0);
      idle(3);
      pin("missing tlast", 0, 2, 0, 1, 1);
      checkLog("missing tlast", 2, 8'b0000_0010);

      // stalled instance, tvalid held high over two frames
      sendFrame(1, 7, 6, -1, '0);
      sendFrame(1, 7, 6, -1, '0);
      idle(3);
      pin("stall", 1, 2, 0, 0, 0);
      lows = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge Clk);
         if (!tready[1]) lows++;
      end
      chk("stall low cycles in 8", 1, lows, 2);

      // reset in the middle of a frame
      sendBeat(0, 8'd0, 1'b0, 1'b0);
      sendBeat(0, 8'd1, 1'b0, 1'b0);
      sendBeat(0, 8'd2, 1'b0, 1'b0);
      @(negedge Clk);
      tdata[0] = 8'd3;
      tvalid[0] = 1'b1;
      Reset = 1'b1;
      #1;
      chk("mid-frame reset tready", 0, tready[0], 0);
      chk("mid-frame reset FrameCount", 0, frameCount[0], 0);
      chk("mid-frame reset LenErrCount", 0, lenErrCount[0], 0);
      chk("mid-frame reset ErrorFlag", 0, errorFlag[0], 0);
      chk("mid-frame reset FrameCount", 1, frameCount[1], 0);
      @(negedge Clk);
      tvalid[0] = 1'b0;
      @(negedge Clk);
      Reset = 1'b0;
      doneLog.delete();
      sendFrame(0, 7, 6, -1, '0);
      idle(3);
      pin("after reset", 0, 1, 0, 0, 0);
      checkLog("after reset", 1, 8'b0000_0001);

      // ClearCounters on the same beat as a data error
      for (int k = 0; k < 7; k++) sendBeat(0, (k == 2) ? 8'd5 : DW'(k), (k == 6), (k == 2));
      idle(3);
      pin("clear vs error", 0, 1, 0, 0, 0);
      checkLog("clear vs error", 2, 8'b0000_0001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/axis_frame_checker.md
Name: axis_frame_checker

Overview:
AXI4-Stream slave that sits directly downstream of the sample generator and consumes its frames. It checks every accepted beat against the expected incrementing pattern: data restarts at 0 each frame and tlast falls on beat FrameSize-1. It counts frames, data errors and length errors, and can apply periodic backpressure to exercise the producer's handshake.

Parameters:
C_S_AXIS_TDATA_WIDTH, 8, stream data width; expected data is the beat index truncated to this width
C_CNT_WIDTH, 16, width of the statistics counters (saturating)
C_STALL_PERIOD, 0, 0 = no stall; N>=2 = tready forced low for 1 cycle in every N cycles

Ports:
Clk  in  1  single clock, all logic on rising edge
Reset  in  1  asynchronous, active-high reset
En  in  1  enables acceptance; tready is 0 while En=0
FrameSize  in  8  expected beats per frame; 0 means 256
ClearCounters  in  1  synchronous clear of statistics and ErrorFlag
S_AXIS_tdata  in  C_S_AXIS_TDATA_WIDTH  stream data
S_AXIS_tvalid  in  1  stream valid
S_AXIS_tlast  in  1  end of frame
S_AXIS_tready  out  1  stream ready
FrameCount  out  C_CNT_WIDTH  frames terminated by an accepted tlast
DataErrCount  out  C_CNT_WIDTH  beats with tdata != expected
LenErrCount  out  C_CNT_WIDTH  early or missing tlast events
ErrorFlag  out  1  sticky; set on any error
FrameDone  out  1  1-cycle pulse, the cycle after tlast is accepted
FrameOk  out  1  valid with FrameDone; 1 = frame had no errors

Behaviour:
- Reset values: all counters 0, ErrorFlag 0, FrameDone 0, FrameOk 0, state IDLE, BeatCnt 0, stall counter 0.
- Reset is asynchronous and may arrive mid-frame. Every register returns to its reset value. After release, the next accepted beat is treated as beat 0 of a new frame.
- Accept = S_AXIS_tvalid & S_AXIS_tready.
- S_AXIS_tready = En & ~stall & (Reset low). stall comes from a free-running modulo-C_STALL_PERIOD counter and is 1 when that count is 0. The ready path from registered state has no combinational dependence on tvalid.
- States:
  - IDLE: on accept, latch FrameSizeR <= FrameSize, check the beat as index 0, go to IN_FRAME. A tlast on this same beat is handled per the rules below.
  - IN_FRAME: check each accepted beat. last_exp = (BeatCnt == FrameSizeR-1), 8-bit wrap.
  - RESYNC: no data or length checks. On an accepted tlast, end the frame and go to IDLE.
- Per-beat checks (IDLE and IN_FRAME):
  - tdata != BeatCnt: DataErrCount +1, frame marked bad.
  - tlast & ~last_exp: early tlast. LenErrCount +1, frame marked bad, frame ends.
  - ~tlast & last_exp: missing tlast. LenErrCount +1, frame marked bad, go to RESYNC.
  - Otherwise BeatCnt +1.
- A data error and a length error on the same beat both increment their counters.
- Frame end (any accepted tlast, in any state):
  - FrameCount +1, BeatCnt <= 0, state <= IDLE.
  - Next cycle: FrameDone=1, FrameOk = ~bad. The bad flag is then cleared.
- ErrorFlag is set whenever DataErrCount or LenErrCount increments.
- Counters saturate at all-ones and do not wrap.
- ClearCounters clears all counters and ErrorFlag, and wins over a same-cycle increment. It does not affect state, BeatCnt or the frame-bad flag.
- En=0 mid-frame: tready drops and state/BeatCnt are held. The frame resumes checking when En returns.
- FrameSize changes mid-frame are ignored until the next frame start.
- Latency: counters update 1 cycle after the accept edge; FrameDone/FrameOk update 1 cycle after that same edge.

Decomposition:
- Package axis_chk_pkg: state enum {IDLE, IN_FRAME, RESYNC}, C_CNT_WIDTH default, a saturating-increment function.
- Sub-module axis_ready_throttle: stall-period counter producing the stall signal.

Test Plan:
1. FrameSize=7, stall off, En=1; 3 back-to-back frames of data 0..6 with tlast on 6 -> FrameCount=3, both error counts 0, 3 FrameDone pulses each with FrameOk=1.
2. Same stimulus, but beat 3 of frame 2 carries 8'h09 -> DataErrCount=1, frame 2 FrameOk=0, ErrorFlag=1; frame 3 FrameOk=1.
3. tlast on data 4 (early) -> LenErrCount=1, FrameCount+1, FrameOk=0; the next frame 0..6 passes cleanly.
4. No tlast on data 6, then data 7, 8 with tlast on 8 -> LenErrCount=1, DataErrCount=0 (beats 7 and 8 not checked), FrameCount+1, FrameOk=0.
5. C_STALL_PERIOD=4, tvalid held high across 2 frames -> tready low exactly 1 cycle in 4, no beat lost or duplicated, no errors, FrameCount=2.
6. Reset pulse at beat 3 of a frame, then clean frame -> all outputs 0 during reset, next frame passes. ClearCounters asserted on the same cycle as a data error -> DataErrCount=0, ErrorFlag=0.
